// File: rtl/scroll_field_pkg.sv
// Shared types and constants for the scrolling playfield engine.
package scroll_field_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWait,
    StPhys,
    StShift,
    StDrawW,
    StDrawP,
    StOver
  } state_e;

  localparam logic [2:0] COL_WALL   = 3'b111;
  localparam logic [2:0] COL_BG     = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b100;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

endpackage

// File: rtl/scroll_col_buf.sv
// Column-organised wall bitmap: clear port, left-shift with new column in at the
// right edge, one random bit read for the rasteriser and combinational row/column
// slices for collision tests. Contents are not reset; CLEAR initialises them.
module scroll_col_buf #(
  parameter int unsigned Cols = 120,
  parameter int unsigned Rows = 100,
  parameter int unsigned ColW = 7,
  parameter int unsigned RowW = 7
) (
  input  logic            clk_i,
  input  logic            clr_en_i,
  input  logic [ColW-1:0] clr_col_i,
  input  logic            shift_en_i,
  input  logic [Rows-1:0] shift_data_i,
  input  logic [ColW-1:0] rd_col_i,
  input  logic [RowW-1:0] rd_row_i,
  output logic            rd_bit_o,
  input  logic [RowW-1:0] slice_row_i,
  output logic [Cols-1:0] slice_row_o,
  input  logic [ColW-1:0] slice_col_i,
  output logic [Rows-1:0] slice_col_o
);

  logic [Rows-1:0] mem_q [Cols];
  logic [Rows-1:0] mem_d [Cols];

  // Next bitmap: shift takes priority; clear writes a single column.
  always_comb begin
    mem_d = mem_q;
    if (shift_en_i) begin
      for (int c = 0; c < Cols - 1; c++) begin
        mem_d[c] = mem_q[c+1];
      end
      mem_d[Cols-1] = shift_data_i;
    end else if (clr_en_i) begin
      mem_d[clr_col_i] = '0;
    end
  end

  // Bitmap storage.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Random read for drawing; out-of-range indices read as empty.
  always_comb begin
    rd_bit_o = 1'b0;
    if (32'(rd_col_i) < Cols && 32'(rd_row_i) < Rows) begin
      rd_bit_o = mem_q[rd_col_i][rd_row_i];
    end
  end

  // Collision slices: one row across all columns, one full column.
  always_comb begin
    slice_row_o = '0;
    slice_col_o = '0;
    if (32'(slice_row_i) < Rows) begin
      for (int c = 0; c < Cols; c++) begin
        slice_row_o[c] = mem_q[c][slice_row_i];
      end
    end
    if (32'(slice_col_i) < Cols) begin
      slice_col_o = mem_q[slice_col_i];
    end
  end

endmodule

// File: rtl/scroll_field.sv
// Scrolling playfield engine: game-state FSM, player physics and a pixel
// rasteriser feeding vga_adapter. Optional score counter enabled by the
// SCROLL_FIELD_SCORE_EN macro; without it score is tied to zero.
module scroll_field
  import scroll_field_pkg::*;
#(
  parameter int unsigned COLS  = 120,
  parameter int unsigned ROWS  = 100,
  parameter int unsigned X_OFF = 20,
  parameter int unsigned Y_OFF = 10,
  parameter int unsigned PW    = 4,
  parameter int unsigned PH    = 6,
  parameter int unsigned PX0   = 20,
  parameter int unsigned PY0   = 90
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic            grav,
  input  logic            col_valid,
  input  logic [ROWS-1:0] col_data,
  output logic            col_ready,
  output logic            busy,
  output logic            game_over,
  output logic [7:0]      x,
  output logic [6:0]      y,
  output logic [2:0]      colour,
  output logic            plot,
  output logic [7:0]      player_x,
  output logic [6:0]      player_y,
  output logic [15:0]     score
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_c_q, cnt_c_d;
  logic [RW-1:0] cnt_r_q, cnt_r_d;
  logic [7:0]    px_q, px_d;
  logic [6:0]    py_q, py_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          score_inc, score_clr;

  logic            clr_en, shift_en, rd_bit;
  logic [ROWS-1:0] slice_col;
  logic [COLS-1:0] slice_row;
  logic [RW-1:0]   slice_row_idx;
  logic [CW-1:0]   slice_col_idx;

  logic [7:0]      tr, hc, y_sum;
  logic            v_oob, v_blocked, push;
  logic [6:0]      py_new;
  logic [COLS-1:0] row_sh;
  logic [ROWS-1:0] col_sh;

  scroll_col_buf #(
    .Cols (COLS),
    .Rows (ROWS),
    .ColW (CW),
    .RowW (RW)
  ) u_buf (
    .clk_i        (clk),
    .clr_en_i     (clr_en),
    .clr_col_i    (cnt_c_q),
    .shift_en_i   (shift_en),
    .shift_data_i (col_data),
    .rd_col_i     (cnt_c_q),
    .rd_row_i     (cnt_r_q),
    .rd_bit_o     (rd_bit),
    .slice_row_i  (slice_row_idx),
    .slice_row_o  (slice_row),
    .slice_col_i  (slice_col_idx),
    .slice_col_o  (slice_col)
  );

  assign slice_row_idx = RW'(tr);
  assign slice_col_idx = CW'(hc);

  // Physics: vertical move first, then wall push test at the post-move height.
  always_comb begin
    if (grav) begin
      v_oob = (py_q == 7'd0);
      tr    = {1'b0, py_q} - 8'd1;
    end else begin
      tr    = {1'b0, py_q} + 8'(PH);
      v_oob = (tr >= 8'(ROWS));
    end
    row_sh    = slice_row >> px_q;
    v_blocked = v_oob || (|row_sh[PW-1:0]);
    if (v_blocked) begin
      py_new = py_q;
    end else if (grav) begin
      py_new = py_q - 7'd1;
    end else begin
      py_new = py_q + 7'd1;
    end
    hc     = px_q + 8'(PW);
    col_sh = slice_col >> py_new;
    push   = (hc < 8'(COLS)) && (|col_sh[PH-1:0]);
  end

  // Next-state, counters, player position and registered pixel outputs.
  always_comb begin
    state_d   = state_q;
    cnt_c_d   = cnt_c_q;
    cnt_r_d   = cnt_r_q;
    px_d      = px_q;
    py_d      = py_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    clr_en    = 1'b0;
    shift_en  = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;
    y_sum     = '0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StClear;
          cnt_c_d = '0;
        end
      end
      StClear: begin
        clr_en    = 1'b1;
        px_d      = 8'(PX0);
        py_d      = 7'(PY0);
        score_clr = 1'b1;
        if (cnt_c_q == CW'(COLS - 1)) begin
          cnt_c_d = '0;
          state_d = StWait;
        end else begin
          cnt_c_d = cnt_c_q + 1'b1;
        end
      end
      StWait: begin
        if (step) begin
          state_d = StPhys;
        end
      end
      StPhys: begin
        py_d    = py_new;
        state_d = StShift;
        if (push) begin
          if (px_q == 8'd0) begin
            state_d = StOver;
          end else begin
            px_d = px_q - 8'd1;
          end
        end
      end
      StShift: begin
        if (col_valid) begin
          if (col_data == '0) begin
            state_d = StOver;
          end else begin
            shift_en  = 1'b1;
            score_inc = 1'b1;
            cnt_c_d   = '0;
            cnt_r_d   = '0;
            state_d   = StDrawW;
          end
        end
      end
      StDrawW: begin
        plot_d   = 1'b1;
        x_d      = 8'(X_OFF) + 8'(cnt_c_q);
        y_sum    = 8'(Y_OFF) + 8'(cnt_r_q);
        y_d      = y_sum[6:0];
        colour_d = rd_bit ? COL_WALL : COL_BG;
        if (cnt_r_q == RW'(ROWS - 1)) begin
          cnt_r_d = '0;
          if (cnt_c_q == CW'(COLS - 1)) begin
            cnt_c_d = '0;
            state_d = StDrawP;
          end else begin
            cnt_c_d = cnt_c_q + 1'b1;
          end
        end else begin
          cnt_r_d = cnt_r_q + 1'b1;
        end
      end
      StDrawP: begin
        plot_d   = 1'b1;
        x_d      = 8'(X_OFF) + px_q + 8'(cnt_c_q);
        y_sum    = 8'(Y_OFF) + {1'b0, py_q} + 8'(cnt_r_q);
        y_d      = y_sum[6:0];
        colour_d = COL_PLAYER;
        if (cnt_r_q == RW'(PH - 1)) begin
          cnt_r_d = '0;
          if (cnt_c_q == CW'(PW - 1)) begin
            cnt_c_d = '0;
            state_d = StWait;
          end else begin
            cnt_c_d = cnt_c_q + 1'b1;
          end
        end else begin
          cnt_r_d = cnt_r_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_c_q  <= '0;
      cnt_r_q  <= '0;
      px_q     <= 8'(PX0);
      py_q     <= 7'(PY0);
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_c_q  <= cnt_c_d;
      cnt_r_q  <= cnt_r_d;
      px_q     <= px_d;
      py_q     <= py_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

`ifdef SCROLL_FIELD_SCORE_EN
  logic [15:0] score_q, score_d;

  // Saturating count of columns scrolled in this game.
  always_comb begin
    score_d = score_q;
    if (score_clr) begin
      score_d = '0;
    end else if (score_inc && score_q != 16'hFFFF) begin
      score_d = score_q + 16'd1;
    end
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  logic unused_score;
  assign unused_score = score_inc ^ score_clr;
  assign score        = 16'd0;
`endif

  assign busy      = !(state_q == StIdle || state_q == StWait || state_q == StOver);
  assign game_over = (state_q == StOver);
  assign col_ready = (state_q == StShift);
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign player_x  = px_q;
  assign player_y  = py_q;

endmodule

// File: tb/tb_scroll_field.sv
// Bench for scroll_field on a small 8x10 field. Each step pushes the expected
// frame pixels into a queue; a negedge monitor pops one per plot and compares.
module tb_scroll_field;

  localparam int unsigned COLS  = 8;
  localparam int unsigned ROWS  = 10;
  localparam int unsigned X_OFF = 20;
  localparam int unsigned Y_OFF = 10;
  localparam int unsigned PW    = 2;
  localparam int unsigned PH    = 3;
  localparam int unsigned PX0   = 2;
  localparam int unsigned PY0   = 4;
  localparam int FRAME = 2 + COLS * ROWS + PW * PH;  // 88 busy cycles per frame

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] col;
  } pix_t;

  logic            clk, reset, start, step, grav, col_valid;
  logic [ROWS-1:0] col_data;
  logic            col_ready, busy, game_over, plot;
  logic [7:0]      x, player_x;
  logic [6:0]      y, player_y;
  logic [2:0]      colour;
  logic [15:0]     score;

  pix_t            exp_q[$];
  logic [ROWS-1:0] model_map [COLS];
  logic [ROWS-1:0] ceil_col, wall_col, zero_col;
  int              checks = 0;
  int              errors = 0;
  int              exp_score = 0;

  scroll_field #(
    .COLS (COLS), .ROWS (ROWS), .X_OFF (X_OFF), .Y_OFF (Y_OFF),
    .PW (PW), .PH (PH), .PX0 (PX0), .PY0 (PY0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .grav      (grav),
    .col_valid (col_valid),
    .col_data  (col_data),
    .col_ready (col_ready),
    .busy      (busy),
    .game_over (game_over),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .player_x  (player_x),
    .player_y  (player_y),
    .score     (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int exp_sc();
`ifdef SCROLL_FIELD_SCORE_EN
    return exp_score;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor: every plot must match the head of the expected queue.
  always @(negedge clk) begin
    pix_t e;
    if (plot === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot actual x=%0d y=%0d c=%0d required no plot", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, colour} !== e) begin
          errors++;
          $display("FAIL pixel actual x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                   x, y, colour, e.px, e.py, e.col);
        end
      end
    end
  end

  task automatic model_clear();
    for (int ci = 0; ci < COLS; ci++) model_map[ci] = '0;
  endtask

  task automatic model_shift(input logic [ROWS-1:0] d);
    for (int ci = 0; ci < COLS - 1; ci++) model_map[ci] = model_map[ci+1];
    model_map[COLS-1] = d;
  endtask

  task automatic push_frame(input int epx, input int epy);
    logic [ROWS-1:0] colv;
    for (int ci = 0; ci < COLS; ci++) begin
      colv = model_map[ci];
      for (int ri = 0; ri < ROWS; ri++) begin
        exp_q.push_back('{px: 8'(X_OFF + ci), py: 7'(Y_OFF + ri),
                          col: colv[ri] ? 3'b111 : 3'b000});
      end
    end
    for (int i = 0; i < PW; i++) begin
      for (int j = 0; j < PH; j++) begin
        exp_q.push_back('{px: 8'(X_OFF + epx + i), py: 7'(Y_OFF + epy + j), col: 3'b100});
      end
    end
  endtask

  task automatic do_start(input string tag);
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    model_clear();
    exp_score = 0;
    chk({tag, " clear_cycles"}, n, COLS);
    chk({tag, " player_x"}, player_x, PX0);
    chk({tag, " player_y"}, player_y, PY0);
    chk({tag, " score"}, score, 0);
    chk({tag, " game_over"}, game_over, 0);
  endtask

  // One game step from WAIT. hold delays col_valid in SHIFT; inject pulses a
  // stray step mid-frame which must be dropped.
  task automatic do_step(input string tag, input logic g, input logic [ROWS-1:0] data,
                         input int hold, input logic inject, input logic exp_over,
                         input int exp_busy, input int epx, input int epy);
    int n;
    grav      = g;
    col_data  = data;
    col_valid = (hold == 0);
    if (!exp_over) begin
      model_shift(data);
      exp_score++;
      push_frame(epx, epy);
    end
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      if (hold > 0 && n == 2 + hold) begin
        chk({tag, " col_ready_stall"}, col_ready, 1);
        col_valid = 1'b1;
      end
      step = (inject && n == 30);
      @(posedge clk); #1;
    end
    step = 1'b0;
    chk({tag, " busy_cycles"}, n, exp_busy);
    chk({tag, " game_over"}, game_over, exp_over);
    chk({tag, " player_x"}, player_x, epx);
    chk({tag, " player_y"}, player_y, epy);
    chk({tag, " score"}, score, exp_sc());
    col_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, " plot_idle"}, plot, 0);
    chk({tag, " frame_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ceil_col = '0;
    ceil_col[0] = 1'b1;
    wall_col = '1;
    zero_col = '0;
    reset = 1'b1; start = 1'b0; step = 1'b0; grav = 1'b0;
    col_valid = 1'b0; col_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst game_over", game_over, 0);
    chk("rst plot", plot, 0);
    chk("rst x", x, 0);
    chk("rst y", y, 0);
    chk("rst colour", colour, 0);
    chk("rst col_ready", col_ready, 0);
    chk("rst score", score, 0);
    chk("rst player_x", player_x, PX0);
    chk("rst player_y", player_y, PY0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Game 1: fall to the bottom edge, climb to a ceiling, then get pushed off.
    do_start("g1");
    do_step("g1s1", 1'b0, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 5);
    do_step("g1s2", 1'b0, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 6);
    do_step("g1s3", 1'b0, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 7);
    do_step("g1s4", 1'b0, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 7);
    do_step("g1s5", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 6);
    do_step("g1s6", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 5);
    do_step("g1s7", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 4);
    do_step("g1s8", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 3);
    do_step("g1s9", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 2);
    do_step("g1s10", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 1);
    do_step("g1s11", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 1);
    do_step("g1s12", 1'b1, wall_col, 0, 1'b0, 1'b0, FRAME, 2, 1);
    do_step("g1s13", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 1);
    do_step("g1s14", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 1);
    do_step("g1s15", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 2, 1);
    do_step("g1s16", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 1, 1);
    do_step("g1s17", 1'b1, ceil_col, 0, 1'b0, 1'b0, FRAME, 0, 1);
    do_step("g1s18", 1'b1, ceil_col, 0, 1'b0, 1'b1, 1, 0, 1);

    // Game 2: stalled column, dropped stray step, end-of-map column.
    do_start("g2");
    do_step("g2s1", 1'b0, ceil_col, 50, 1'b0, 1'b0, FRAME + 50, 2, 5);
    do_step("g2s2", 1'b0, ceil_col, 0, 1'b1, 1'b0, FRAME, 2, 6);
    repeat (20) @(posedge clk);
    #1;
    chk("g2 stray_step_busy", busy, 0);
    chk("g2 stray_step_plot", plot, 0);
    do_step("g2s3", 1'b0, zero_col, 0, 1'b0, 1'b1, 2, 2, 7);

    // Game 3: reset in the middle of the wall raster.
    do_start("g3");
    begin
      int n;
      grav = 1'b0; col_data = ceil_col; col_valid = 1'b1;
      model_shift(ceil_col);
      push_frame(2, 5);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      n = 1;
      while (n < 40) begin
        n++;
        @(posedge clk); #1;
      end
      chk("g3 mid_draw_plot", plot, 1);
      chk("g3 mid_draw_score", score, (exp_sc() == 0) ? 0 : 1);
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      chk("g3 rst_plot", plot, 0);
      chk("g3 rst_busy", busy, 0);
      chk("g3 rst_game_over", game_over, 0);
      chk("g3 rst_score", score, 0);
      chk("g3 rst_player_x", player_x, PX0);
      chk("g3 rst_player_y", player_y, PY0);
      reset = 1'b0;
      col_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("g3 idle_after_rst", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
